pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage ARM pipeline. It compares the decode-stage source registers against in-flight destinations to drive the decode stage's hazard input. It also freezes the whole pipeline while a data-memory access waits on a multi-cycle memory, and flushes the front end on a taken branch. It keeps a wait-state FSM with timeout, plus saturating stall/flush statistics counters.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, max consecutive memory wait cycles before forced release (≥2)
- CNT_W, 16, width of statistics counters

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- src1In  in  4  decode-stage Rn
- src2In  in  4  decode-stage second source (Rm, or Rd for stores)
- TwoSrcIn  in  1  src2In is a real operand
- EXE_DestIn  in  4  destination in EXE
- EXE_WB_ENIn  in  1  EXE instruction writes back
- EXE_MEM_R_ENIn  in  1  EXE instruction is a load
- MEM_DestIn  in  4  destination in MEM
- MEM_WB_ENIn  in  1  MEM instruction writes back
- memReqIn  in  1  MEM stage has a load/store active this cycle
- memReadyIn  in  1  memory completes the access this cycle
- branchTakenIn  in  1  taken branch resolved in EXE
- HazardOut  out  1  to decode-stage hazard input (bubble into ID/EXE)
- freezeOut  out  1  hold PC and IF/ID register
- memStallOut  out  1  hold all pipeline registers
- flushOut  out  1  clear IF/ID and ID/EXE
- timeoutErrOut  out  1  sticky: a memory wait hit TIMEOUT_CYCLES
- stateOut  out  2  FSM state (0 RUN, 1 MEM_WAIT)
- stallCntOut  out  CNT_W  cycles with freezeOut=1, saturating
- flushCntOut  out  CNT_W  cycles with flushOut=1, saturating

## Operation
- Raw hazard (no forwarding): (EXE_WB_ENIn & src1In==EXE_DestIn) | (MEM_WB_ENIn & src1In==MEM_DestIn) | TwoSrcIn & (same compares on src2In). src1 is always compared.
- FSM RUN: memStallOut = memReqIn & ~memReadyIn. If memStallOut=1, go to MEM_WAIT and set waitCnt=1.
- FSM MEM_WAIT: memStallOut = ~memReadyIn & (waitCnt != TIMEOUT_CYCLES-1).
  - On memReadyIn: go to RUN and clear waitCnt.
  - On waitCnt == TIMEOUT_CYCLES-1 without ready: set timeoutErrOut, go to RUN. memStallOut is 0 that cycle (forced release).
  - Otherwise waitCnt increments.
- flushOut = branchTakenIn & ~memStallOut. A flush is deferred while memory-stalled; the branch stays held in EXE because the pipeline is frozen.
- HazardOut = raw hazard & ~flushOut & ~memStallOut.
- freezeOut = HazardOut | memStallOut.
- stallCntOut increments on each cycle with freezeOut=1; flushCntOut increments on each cycle with flushOut=1. Both saturate at all-ones and never wrap.
- timeoutErrOut clears only on reset.

## Timing
- HazardOut, freezeOut, memStallOut and flushOut are combinational, with zero-cycle latency from their inputs.
- FSM state, waitCnt, counters and timeoutErrOut update on the rising clk edge.
- While rst=1: state RUN, waitCnt=0, all counters 0, timeoutErrOut=0, and every output 0, including the combinational ones, which are gated by ~rst.
- Reset asserted mid-wait aborts the wait immediately. After release the FSM restarts in RUN.
- memReqIn & memReadyIn in the same RUN cycle is a single-cycle access: no stall, no state change.
- A branch and a hazard in the same cycle resolve to the branch: flushOut=1, HazardOut=0.
- A branch during a stall is deferred: flushOut asserts in the first cycle after memStallOut drops.
- At the timeout boundary, a wait of TIMEOUT_CYCLES-1 stalled cycles followed by ready in the next cycle is a normal completion; the error is raised only on the forced-release cycle.

## Configuration
- FORWARDING_EN defined:
  - Forwarding unit present; raw hazard = EXE_MEM_R_ENIn & EXE_WB_ENIn & (src1In==EXE_DestIn | TwoSrcIn & src2In==EXE_DestIn). This is load-use only.
  - MEM-stage compares are removed.
- FORWARDING_EN undefined:
  - Full EXE+MEM compare as in Operation.
  - The MEM_DestIn and MEM_WB_ENIn ports remain present either way.

## Test plan
- Hazard detection, FORWARDING_EN off: src1In=3, EXE_DestIn=3, EXE_WB_ENIn=1 -> HazardOut=1 and freezeOut=1 the same cycle. With src2In=5, TwoSrcIn=0, MEM_DestIn=5 -> no hazard.
- Load-use, FORWARDING_EN on: the same EXE match with EXE_MEM_R_ENIn=0 -> HazardOut=0; with EXE_MEM_R_ENIn=1 -> HazardOut=1. A MEM match alone -> 0.
- Memory wait: memReqIn=1 with memReadyIn low for 4 cycles, then high -> memStallOut=1 for 4 cycles, stateOut 1 then 0, stallCntOut=4.
- Timeout: TIMEOUT_CYCLES=8, memReadyIn never high -> memStallOut=1 for 7 cycles, 0 on the 8th, then timeoutErrOut=1 until rst.
- Branch deferral: branchTakenIn=1 during a 3-cycle memory stall, with a hazard also present -> flushOut=0 for 3 cycles, then 1 with HazardOut=0; flushCntOut=1.
- Reset mid-wait: assert rst in cycle 2 of MEM_WAIT -> all outputs 0 asynchronously, counters 0, stateOut=0 after release.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller_if
// Brief   : Decode/EXE/MEM hazard and memory-handshake bundle for the
//           pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       src1In;
    logic [3:0]       src2In;
    logic             TwoSrcIn;
    logic [3:0]       EXE_DestIn;
    logic             EXE_WB_ENIn;
    logic             EXE_MEM_R_ENIn;
    logic [3:0]       MEM_DestIn;
    logic             MEM_WB_ENIn;
    logic             memReqIn;
    logic             memReadyIn;
    logic             branchTakenIn;
    logic             HazardOut;
    logic             freezeOut;
    logic             memStallOut;
    logic             flushOut;
    logic             timeoutErrOut;
    logic [1:0]       stateOut;
    logic [CNT_W-1:0] stallCntOut;
    logic [CNT_W-1:0] flushCntOut;

    modport master (
        output src1In, src2In, TwoSrcIn, EXE_DestIn, EXE_WB_ENIn, EXE_MEM_R_ENIn,
               MEM_DestIn, MEM_WB_ENIn, memReqIn, memReadyIn, branchTakenIn,
        input  HazardOut, freezeOut, memStallOut, flushOut, timeoutErrOut,
               stateOut, stallCntOut, flushCntOut
    );

    modport slave (
        input  src1In, src2In, TwoSrcIn, EXE_DestIn, EXE_WB_ENIn, EXE_MEM_R_ENIn,
               MEM_DestIn, MEM_WB_ENIn, memReqIn, memReadyIn, branchTakenIn,
        output HazardOut, freezeOut, memStallOut, flushOut, timeoutErrOut,
               stateOut, stallCntOut, flushCntOut
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Brief   : Stall/flush sequencer: RAW hazard detect, memory wait FSM with
//           timeout, taken-branch flush, saturating statistics.
//           Option macro FORWARDING_EN reduces hazard detect to load-use only.
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    pipeline_hazard_controller_if.slave bus
);
    localparam int              WAIT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);
    localparam logic [1:0]      ST_RUN      = 2'd0;
    localparam logic [1:0]      ST_MEM_WAIT = 2'd1;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic w_raw_hazard;
    logic w_mem_stall;
    logic w_flush;
    logic w_hazard;
    logic w_freeze;

`ifdef FORWARDING_EN
    logic [4:0] w_unused_mem;
    assign w_unused_mem = {bus.MEM_DestIn, bus.MEM_WB_ENIn};
    assign w_raw_hazard = bus.EXE_MEM_R_ENIn & bus.EXE_WB_ENIn &
                          ((bus.src1In == bus.EXE_DestIn) |
                           (bus.TwoSrcIn & (bus.src2In == bus.EXE_DestIn)));
`else
    logic w_unused_ld;
    assign w_unused_ld  = bus.EXE_MEM_R_ENIn;
    assign w_raw_hazard = (bus.EXE_WB_ENIn & (bus.src1In == bus.EXE_DestIn)) |
                          (bus.MEM_WB_ENIn & (bus.src1In == bus.MEM_DestIn)) |
                          (bus.TwoSrcIn &
                           ((bus.EXE_WB_ENIn & (bus.src2In == bus.EXE_DestIn)) |
                            (bus.MEM_WB_ENIn & (bus.src2In == bus.MEM_DestIn))));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN: begin
                if (w_mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = c_WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.memReadyIn) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == c_WAIT_LAST) begin
                    // Forced release: the access is abandoned and flagged
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_WAIT_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (w_freeze && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (w_flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_comb begin
        w_mem_stall = 1'b0;
        case (state_q)
            ST_RUN:      w_mem_stall = bus.memReqIn & ~bus.memReadyIn;
            ST_MEM_WAIT: w_mem_stall = ~bus.memReadyIn & (wait_cnt_q != c_WAIT_LAST);
            default:     w_mem_stall = 1'b0;
        endcase
        w_mem_stall = w_mem_stall & ~rst;
        // Branch wins over hazard; both yield to a memory freeze
        w_flush  = ~rst & bus.branchTakenIn & ~w_mem_stall;
        w_hazard = ~rst & w_raw_hazard & ~w_flush & ~w_mem_stall;
        w_freeze = w_hazard | w_mem_stall;
    end

    assign bus.HazardOut     = w_hazard;
    assign bus.freezeOut     = w_freeze;
    assign bus.memStallOut   = w_mem_stall;
    assign bus.flushOut      = w_flush;
    assign bus.timeoutErrOut = timeout_err_q;
    assign bus.stateOut      = state_q;
    assign bus.stallCntOut   = stall_cnt_q;
    assign bus.flushCntOut   = flush_cnt_q;
endmodule
`default_nettype wire
